// File: rtl/sum_seg_pkg.sv
// sum_seg_pkg
// Shared definitions for the pipelined carry-lookahead adder/subtractor.
//   SUM_SEG_WIDTH  default operand/result width
//   SUM_SEG_SLICE  default bits per lookahead slice (one slice per stage)
//   sum_seg_stages number of pipeline stages for a given width and slice
package sum_seg_pkg;

  localparam int SUM_SEG_WIDTH = 16;
  localparam int SUM_SEG_SLICE = 4;

  // One lookahead slice is handled per pipeline stage.
  function automatic int sum_seg_stages(input int width, input int slice);
    return width / slice;
  endfunction

endpackage

// File: rtl/sum_seg_cla.sv
// sum_cla
// Purely combinational SLICE-bit carry-lookahead slice.
//   A, B      slice operands (B already inverted by the caller for subtract)
//   c_in      carry into bit 0 of the slice
//   S         slice sum
//   c_out     carry out of the slice MSB
//   c_msb_in  carry into the slice MSB, used for two's-complement overflow
module sum_cla
  import sum_seg_pkg::*;
#(
  parameter int SLICE = SUM_SEG_SLICE
) (
  output logic [SLICE-1:0] S,
  output logic             c_out,
  output logic             c_msb_in,
  input  logic [SLICE-1:0] A,
  input  logic [SLICE-1:0] B,
  input  logic             c_in
);

  logic [SLICE-1:0] gen;
  logic [SLICE-1:0] prop;
  logic [SLICE:0]   carry;

  assign gen  = A & B;
  assign prop = A ^ B;

  // Every carry is formed directly from generate/propagate terms and c_in
  // (sum of products), so no carry waits on a lower carry inside the slice.
  always_comb begin
    logic acc;
    logic prop_run;
    carry    = '0;
    acc      = 1'b0;
    prop_run = 1'b1;
    carry[0] = c_in;
    for (int i = 0; i < SLICE; i++) begin
      acc      = 1'b0;
      prop_run = 1'b1;
      for (int j = i; j >= 0; j--) begin
        acc      = acc | (gen[j] & prop_run);
        prop_run = prop_run & prop[j];
      end
      carry[i+1] = acc | (prop_run & c_in);
    end
  end

  assign S        = prop ^ carry[SLICE-1:0];
  assign c_out    = carry[SLICE];
  assign c_msb_in = carry[SLICE-1];

endmodule

// File: rtl/sum_seg.sv
// sum_seg
// Pipelined carry-lookahead adder/subtractor with valid/ready handshake.
// Each stage adds one SLICE-bit slice and registers its carry for the next.
//   clk, reset          clock and asynchronous active-high reset
//   in_valid, in_ready  operand handshake (in_ready = !out_valid || out_ready)
//   A, B, c_in, sub     operands; sub=1 computes A-B and ignores c_in
//   out_valid, out_ready result handshake
//   S, c_out, ovf       registered sum/difference, carry out, overflow
module sum_seg
  import sum_seg_pkg::*;
#(
  parameter int WIDTH = SUM_SEG_WIDTH,
  parameter int SLICE = SUM_SEG_SLICE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             c_out,
  output logic             ovf
);

  localparam int STAGES = sum_seg_stages(WIDTH, SLICE);

  if (WIDTH % SLICE != 0) begin : g_width_check
    $error("sum_seg: WIDTH must be a multiple of SLICE");
  end

  logic             en;
  logic [WIDTH-1:0] b_eff;

  // The whole pipeline freezes while a result waits for its consumer.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Subtraction inverts B once at the input; the +1 enters as stage 0 carry.
  assign b_eff = B ^ {WIDTH{sub}};

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LOW = (k + 1) * SLICE;
    localparam int REM = WIDTH - LOW;

    logic [SLICE-1:0] a_sl;
    logic [SLICE-1:0] b_sl;
    logic [SLICE-1:0] sum_sl;
    logic             c_src;
    logic             v_src;
    logic             c_slice;
    logic             c_msb_tap;
    logic [LOW-1:0]   s_nxt;
    logic [LOW-1:0]   s_q;
    logic             c_q;
    logic             v_q;

    // Stage 0 reads the ports; later stages read the skewed operand bits,
    // carry, valid and completed low result bits held by the stage before.
    if (k == 0) begin : g_src
      assign a_sl  = A[SLICE-1:0];
      assign b_sl  = b_eff[SLICE-1:0];
      assign c_src = sub | c_in;
      assign v_src = in_valid;
      assign s_nxt = sum_sl;
    end else begin : g_src
      assign a_sl  = g_stage[k-1].g_ops.a_q[SLICE-1:0];
      assign b_sl  = g_stage[k-1].g_ops.b_q[SLICE-1:0];
      assign c_src = g_stage[k-1].c_q;
      assign v_src = g_stage[k-1].v_q;
      assign s_nxt = {sum_sl, g_stage[k-1].s_q};
    end

    sum_cla #(
      .SLICE(SLICE)
    ) u_cla (
      .S        (sum_sl),
      .c_out    (c_slice),
      .c_msb_in (c_msb_tap),
      .A        (a_sl),
      .B        (b_sl),
      .c_in     (c_src)
    );

    // Stage valid, carry and deskewed result bits.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (en) begin
        v_q <= v_src;
        c_q <= c_slice;
        s_q <= s_nxt;
      end
    end

    // Operand skew: only the slices still to be added travel onward.
    if (REM > 0) begin : g_ops
      logic [REM-1:0] a_q;
      logic [REM-1:0] b_q;
      logic [REM-1:0] a_nxt;
      logic [REM-1:0] b_nxt;

      if (k == 0) begin : g_fwd
        assign a_nxt = A[WIDTH-1:SLICE];
        assign b_nxt = b_eff[WIDTH-1:SLICE];
      end else begin : g_fwd
        assign a_nxt = g_stage[k-1].g_ops.a_q[REM+SLICE-1:SLICE];
        assign b_nxt = g_stage[k-1].g_ops.b_q[REM+SLICE-1:SLICE];
      end

      // Remaining high operand bits for the later stages.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          a_q <= '0;
          b_q <= '0;
        end else if (en) begin
          a_q <= a_nxt;
          b_q <= b_nxt;
        end
      end
    end

    // Only the top slice sees the word MSB, so only it registers overflow.
    if (k == STAGES - 1) begin : g_last
      logic ovf_q;

      // Overflow is carry into the MSB differing from carry out of it.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          ovf_q <= 1'b0;
        end else if (en) begin
          ovf_q <= c_msb_tap ^ c_slice;
        end
      end
    end else begin : g_mid
      logic msb_unused;
      assign msb_unused = c_msb_tap;
    end
  end

  assign out_valid = g_stage[STAGES-1].v_q;
  assign S         = g_stage[STAGES-1].s_q;
  assign c_out     = g_stage[STAGES-1].c_q;
  assign ovf       = g_stage[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_sum_seg.sv
// tb_sum_seg
// Self-checking bench for sum_seg (WIDTH=16, SLICE=4): directed cases and a
// randomized stream compared against an arithmetic scoreboard model.
module tb_sum_seg;

  localparam int WIDTH  = 16;
  localparam int SLICE  = 4;
  localparam int STAGES = WIDTH / SLICE;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             c_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] S;
  logic             c_out;
  logic             ovf;

  typedef struct {
    logic [WIDTH-1:0] s;
    logic             co;
    logic             ov;
    int               age;
  } expT;

  expT expQ[$];
  int  testCount;
  int  failCount;

  sum_seg #(
    .WIDTH(WIDTH),
    .SLICE(SLICE)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .c_in      (c_in),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (S),
    .c_out     (c_out),
    .ovf       (ovf)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point; every check is counted and reported here.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    testCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain wide arithmetic on the operands; overflow from signs.
  function automatic expT model(input logic [WIDTH-1:0] a,
                                input logic [WIDTH-1:0] b,
                                input logic ci, input logic sb);
    expT e;
    logic [WIDTH-1:0] bo;
    int unsigned full;
    bo   = sb ? ~b : b;
    full = int'(a) + int'(bo) + (sb ? 1 : int'(ci));
    e.s   = full[WIDTH-1:0];
    e.co  = full[WIDTH];
    e.ov  = (a[WIDTH-1] == bo[WIDTH-1]) && (e.s[WIDTH-1] != a[WIDTH-1]);
    e.age = 1;
    return e;
  endfunction

  // One cycle: drive inputs at the falling edge, then predict what the next
  // rising edge does and compare the settled outputs against the model.
  task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b, input logic ci,
                               input logic sb, input logic ordy);
    logic expOv;
    logic expEn;
    @(negedge clk);
    in_valid  = v;
    A         = a;
    B         = b;
    c_in      = ci;
    sub       = sb;
    out_ready = ordy;
    #1;
    expOv = (expQ.size() > 0) && (expQ[0].age == STAGES);
    expEn = !expOv || ordy;
    checkOutput("out_valid", {31'd0, out_valid}, {31'd0, expOv});
    checkOutput("in_ready", {31'd0, in_ready}, {31'd0, expEn});
    if (expOv) begin
      checkOutput("S", {16'd0, S}, {16'd0, expQ[0].s});
      checkOutput("c_out", {31'd0, c_out}, {31'd0, expQ[0].co});
      checkOutput("ovf", {31'd0, ovf}, {31'd0, expQ[0].ov});
      if (ordy) void'(expQ.pop_front());
    end
    if (expEn) begin
      for (int i = 0; i < expQ.size(); i++) expQ[i].age = expQ[i].age + 1;
      if (v) expQ.push_back(model(a, b, ci, sb));
    end
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  // Directed stream vectors: {A, B, c_in, sub}
  logic [WIDTH-1:0] dirA [8];
  logic [WIDTH-1:0] dirB [8];
  logic             dirC [8];
  logic             dirS [8];

  initial begin
    testCount = 0;
    failCount = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    A         = '0;
    B         = '0;
    c_in      = 1'b0;
    sub       = 1'b0;
    out_ready = 1'b1;

    dirA = '{16'h0000, 16'hFFFF, 16'h8000, 16'h0000,
             16'h5555, 16'h7FFF, 16'h1234, 16'h0F0F};
    dirB = '{16'h0000, 16'h0001, 16'h0001, 16'h0001,
             16'hAAAA, 16'h0001, 16'h4321, 16'hF0F0};
    dirC = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    dirS = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    #23;
    reset = 1'b0;
    #1;
    checkOutput("reset out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset S", {16'd0, S}, 32'd0);
    checkOutput("reset c_out", {31'd0, c_out}, 32'd0);
    checkOutput("reset ovf", {31'd0, ovf}, 32'd0);
    checkOutput("reset in_ready", {31'd0, in_ready}, 32'd1);

    $display("[TB] isolated directed operations");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, dirA[i], dirB[i], dirC[i], dirS[i], 1'b1);
      idleCycles(STAGES + 1);
    end

    $display("[TB] back-to-back stream");
    for (int i = 4; i < 8; i++)
      applyStimulus(1'b1, dirA[i], dirB[i], dirC[i], dirS[i], 1'b1);
    idleCycles(STAGES + 2);

    $display("[TB] back-pressure");
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, dirA[i+4], dirB[i+4], dirC[i+4], dirS[i+4], 1'b1);
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0);
    idleCycles(STAGES + 4);

    $display("[TB] asynchronous reset with operations in flight");
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, dirA[i], dirB[i], dirC[i], dirS[i], 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async reset out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("async reset S", {16'd0, S}, 32'd0);
    expQ.delete();
    @(negedge clk);
    #2;
    reset = 1'b0;
    idleCycles(2 * STAGES);

    $display("[TB] randomized stream");
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 3) != 0), WIDTH'($urandom),
                    WIDTH'($urandom), 1'($urandom), 1'($urandom),
                    ($urandom_range(0, 9) < 7));
    end

    for (int i = 0; i < 50 && expQ.size() > 0; i++) idleCycles(1);
    checkOutput("drain empty", expQ.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/sum_seg.md
# sum_seg

Parametrised, pipelined carry-lookahead adder/subtractor. It is the successor to the fixed 4-bit combinational adder. A WIDTH-bit operation is split into WIDTH/SLICE lookahead slices, one slice per pipeline stage, and the carry is registered between stages. A valid/ready handshake carries one operation per cycle with back-pressure. The block is the arithmetic datapath element for the practice ALU and accumulator designs.

## Interface
Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of SLICE.
- SLICE, 4, bits per lookahead slice; equals the bits handled per pipeline stage.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all pipeline state immediately.
- in_valid  in  1  operands present this cycle.
- in_ready  out  1  block accepts operands this cycle.
- A  in  WIDTH  first operand.
- B  in  WIDTH  second operand.
- c_in  in  1  carry in; ignored when sub=1.
- sub  in  1  0: S = A+B+c_in; 1: S = A+~B+1 (A−B).
- out_valid  out  1  result present.
- out_ready  in  1  consumer takes the result this cycle.
- S  out  WIDTH  sum or difference.
- c_out  out  1  carry out of the MSB; for subtraction, 1 means no borrow.
- ovf  out  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

## Operation
- STAGES = WIDTH/SLICE.
- Transfer rule: a transfer occurs on an edge where valid && ready.
- Stage k (0..STAGES−1) adds operand bits [k·SLICE +: SLICE] with the carry registered by stage k−1. Stage 0 uses c_in, or 1 when sub=1.
- Operand skew: the slices that later stages need are carried forward in per-stage operand registers (triangular skew).
- Result deskew: completed low slices are carried forward in per-stage result registers, so S emerges whole.
- Subtraction: B is inverted at the input stage; the sub bit needs no further registering.
- Each stage holds a valid bit. Bubbles (in_valid=0) propagate as valid=0.
- Stall: en = !out_valid || out_ready.
  - All stages advance only when en=1.
  - in_ready = en, which is combinational from out_valid and out_ready.
  - When en=0, every pipeline register, including S, c_out and ovf, holds.
- No FSM beyond the per-stage valid bits. The pipeline behaves as a fixed-depth shift of operations that can be frozen.
- Reset values:
  - out_valid=0, S=0, c_out=0, ovf=0.
  - All internal valid bits, carries and skew/deskew registers are 0.
  - in_ready=1 while reset is deasserted and the pipeline is empty.
- Reset mid-operation discards every in-flight operation. No result from before reset ever appears on the outputs.
- Wrap-around: the result is modulo 2^WIDTH; the overflow is reported only via c_out and ovf.

## Timing
- Latency: an operation accepted at edge t produces out_valid=1 with its result after edge t+STAGES−1, i.e. STAGES cycles of pipeline occupancy. For the defaults, 4 cycles.
- Throughput: 1 operation per cycle when out_ready is held at 1.
- Ordering: results leave in strict acceptance order.
- Simultaneous accept and emit in the same cycle is legal and loses nothing.
- Outputs are registered. The only combinational in→out path is out_ready→in_ready.
- The critical path is one SLICE-bit lookahead plus one carry mux. It is independent of WIDTH.

## Structure
- Shared header/package: default SLICE and the STAGES derivation macro/function. Also an elaboration check that WIDTH % SLICE == 0; it calls $error/$finish in simulation.
- One sub-module, sum_cla: a purely combinational SLICE-bit lookahead slice. Ports are S, c_out, c_msb_in, A, B, c_in. It computes generate/propagate per bit and lookahead carries, and exposes the carry into its MSB for ovf.
- sum_seg instantiates STAGES copies of sum_cla via a generate loop. The stage, skew and deskew registers are written in the same loop.

## Test plan
All scenarios use WIDTH=16 and SLICE=4.
- Reset, then A=0x0000, B=0x0000, c_in=1, sub=0 → 4 cycles later: out_valid=1, S=0x0001, c_out=0, ovf=0.
- A=0xFFFF, B=0x0001, c_in=0 (carry ripples through all 4 stages) → S=0x0000, c_out=1, ovf=0.
- sub=1, A=0x8000, B=0x0001 → S=0x7FFF, c_out=1, ovf=1. Also sub=1, A=0x0000, B=0x0001 → S=0xFFFF, c_out=0, ovf=0.
- Back-to-back stream, out_ready=1 constant: {0x5555+0xAAAA, 0x7FFF+0x0001, 0x1234+0x4321, c_in=1 on 0x0F0F+0xF0F0} → on 4 consecutive cycles S = 0xFFFF, 0x8000 (ovf=1), 0x5555, 0x0000 (c_out=1), in that order.
- Back-pressure: out_ready=0 for 3 cycles while out_valid=1 → S, c_out, ovf stable and in_ready=0. On release, the queued results emerge without loss or duplication.
- Reset asserted asynchronously with 3 operations in flight → out_valid=0 immediately. After release, nothing emerges until new operands are accepted.
